// File: rtl/alu_share_pkg.sv
// Shared definitions for alu_share_arbiter: ALU function codes and the
// arbiter FSM state encoding.
package alu_share_pkg;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SL   = 4'd1,
        FN_SEQ  = 4'd2,
        FN_SNE  = 4'd3,
        FN_XOR  = 4'd4,
        FN_SR   = 4'd5,
        FN_OR   = 4'd6,
        FN_AND  = 4'd7,
        FN_SUB  = 4'd10,
        FN_SRA  = 4'd11,
        FN_SLT  = 4'd12,
        FN_SGE  = 4'd13,
        FN_SLTU = 4'd14,
        FN_SGEU = 4'd15
    } alu_fn_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_rr_pick.sv
// Combinational round-robin picker: first valid index at or above rr,
// wrapping modulo NUM_REQ, returned both one-hot and as an index.
module alu_share_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    rr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    int                   pos;

    // Rotating a doubled copy right by rr puts requester rr at bit 0, so the
    // lowest set bit of the rotated vector is the round-robin winner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        grant   = '0;
        doubled = {valid, valid};
        rotated = NUM_REQ'(doubled >> rr);
        any     = |valid;
        pos     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) pos = k;
        end
        pos = pos + int'(rr);
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        idx = ID_W'(pos);
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between NUM_REQ requesters.
// Optional perf counters are enabled by defining ALU_SHARE_ARBITER_PERF_EN.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      io_req_valid,
    output logic [NUM_REQ-1:0]      io_req_ready,
    input  logic [4*NUM_REQ-1:0]    io_req_fn,
    input  logic [NUM_REQ-1:0]      io_req_dw,
    input  logic [XLEN*NUM_REQ-1:0] io_req_in1,
    input  logic [XLEN*NUM_REQ-1:0] io_req_in2,
    output logic                    io_resp_valid,
    input  logic                    io_resp_ready,
    output logic [ID_W-1:0]         io_resp_id,
    output logic [XLEN-1:0]         io_resp_data,
    output logic                    io_resp_cmp,
    output logic [3:0]              io_alu_fn,
    output logic                    io_alu_dw,
    output logic [XLEN-1:0]         io_alu_in1,
    output logic [XLEN-1:0]         io_alu_in2,
    input  logic [XLEN-1:0]         io_alu_out,
    input  logic                    io_alu_cmp_out,
    output logic [31:0]             io_perf_busy,
    output logic [31:0]             io_perf_conflict
);

    state_e             state, state_nxt;
    logic [ID_W-1:0]    rr, pend_id, grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               any_valid, can_accept, accept;

    logic [3:0]      fn_arr  [NUM_REQ];
    logic [XLEN-1:0] in1_arr [NUM_REQ];
    logic [XLEN-1:0] in2_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign fn_arr[i]  = io_req_fn[4*i +: 4];
        assign in1_arr[i] = io_req_in1[XLEN*i +: XLEN];
        assign in2_arr[i] = io_req_in2[XLEN*i +: XLEN];
    end

    alu_share_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid (io_req_valid),
        .rr    (rr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (any_valid)
    );

    // Holding reset also holds off acceptance so ready reads 0 during reset.
    assign can_accept    = reset && ((state == IDLE) || ((state == RESP) && io_resp_ready));
    assign accept        = can_accept && any_valid;
    assign io_req_ready  = can_accept ? grant : '0;
    assign io_resp_valid = (state == RESP);

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (io_resp_ready) state_nxt = accept ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_alu_fn    <= '0;
            io_alu_dw    <= 1'b0;
            io_alu_in1   <= '0;
            io_alu_in2   <= '0;
            pend_id      <= '0;
            rr           <= '0;
            io_resp_id   <= '0;
            io_resp_data <= '0;
            io_resp_cmp  <= 1'b0;
        end else begin
            if (accept) begin
                io_alu_fn  <= fn_arr[grant_idx];
                io_alu_dw  <= io_req_dw[grant_idx];
                io_alu_in1 <= in1_arr[grant_idx];
                io_alu_in2 <= in2_arr[grant_idx];
                pend_id    <= grant_idx;
                rr         <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == EXEC) begin
                io_resp_data <= io_alu_out;
                io_resp_cmp  <= io_alu_cmp_out;
                io_resp_id   <= pend_id;
            end
        end
    end

`ifdef ALU_SHARE_ARBITER_PERF_EN
    // v & (v - 1) is nonzero exactly when two or more valid bits are set.
    logic contended;
    assign contended = (io_req_valid & (io_req_valid - 1'b1)) != '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_perf_busy     <= '0;
            io_perf_conflict <= '0;
        end else begin
            if (state != IDLE)          io_perf_busy     <= io_perf_busy + 32'd1;
            if (accept && contended)    io_perf_conflict <= io_perf_conflict + 32'd1;
        end
    end
`else
    assign io_perf_busy     = '0;
    assign io_perf_conflict = '0;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one single-cycle integer ALU (4-bit fn code, 32-bit operands, cmp_out) between NUM_REQ requesters, e.g. the pipeline execute stage and a CSR/debug or address-generation unit.
- Arbitrates round-robin and registers the granted operation into the ALU.
- Captures the ALU result into a response register with a valid/ready handshake, tagged with the requester id.

Parameters:
- NUM_REQ, 2: number of requesters, range 2..8.
- ID_W, 1: response id width; must equal clog2(NUM_REQ).
- XLEN, 32: operand and result width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_req_valid  in  NUM_REQ  per-requester request valid.
- io_req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- io_req_fn  in  4*NUM_REQ  ALU function code; slice i belongs to requester i.
- io_req_dw  in  NUM_REQ  data-width select.
- io_req_in1  in  XLEN*NUM_REQ  operand 1.
- io_req_in2  in  XLEN*NUM_REQ  operand 2.
- io_resp_valid  out  1  result valid.
- io_resp_ready  in  1  consumer accepts result.
- io_resp_id  out  ID_W  requester index of the result.
- io_resp_data  out  XLEN  captured alu io_out.
- io_resp_cmp  out  1  captured alu io_cmp_out.
- io_alu_fn  out  4  registered to shared ALU.
- io_alu_dw  out  1  registered to shared ALU.
- io_alu_in1  out  XLEN  registered to shared ALU.
- io_alu_in2  out  XLEN  registered to shared ALU.
- io_alu_out  in  XLEN  from shared ALU, combinational.
- io_alu_cmp_out  in  1  from shared ALU.
- io_perf_busy  out  32  see Optional Feature.
- io_perf_conflict  out  32  see Optional Feature.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - io_resp_valid=0, io_req_ready=0, io_resp_id=0, io_resp_data=0, io_resp_cmp=0.
  - io_alu_* = 0.
  - Round-robin pointer rr=0.
  - Perf counters = 0.
- Grant computation:
  - Combinational from io_req_valid and rr: the first valid index searched from rr upward, wrapping modulo NUM_REQ.
  - io_req_ready[g]=1 only when accepting: in IDLE, or in RESP while io_resp_ready=1.
  - io_req_ready is 0 in EXEC.
  - Ready depends on valid (grant is a function of valid); requesters must not make valid depend on ready.
- Accept, i.e. a valid&ready handshake on requester g:
  - Latch fn, dw, in1, in2 into io_alu_* registers and latch g as the pending id.
  - Set rr = (g+1) mod NUM_REQ.
  - Next state is EXEC.
- EXEC (exactly one cycle):
  - Capture io_alu_out into io_resp_data, io_alu_cmp_out into io_resp_cmp, and the pending id into io_resp_id.
  - Next state is RESP.
- RESP:
  - io_resp_valid=1; response fields are held stable until the handshake.
  - If io_resp_ready=1 and a request is valid: accept it in the same cycle and go to EXEC (back-to-back).
  - If io_resp_ready=1 and no request is valid: go to IDLE.
  - If io_resp_ready=0: stay in RESP with no acceptance.
- Latency and throughput:
  - Accept at cycle N gives io_resp_valid at N+2.
  - Peak throughput is one op per 2 cycles.
- Boundary conditions:
  - No requests: stay in IDLE; rr unchanged.
  - Single requester valid: granted regardless of rr.
  - All valid continuously: grants rotate 0,1,..,NUM_REQ-1,0.
  - Requester withdraws valid before grant: allowed, nothing latched.
  - Reset asserted mid-EXEC or mid-RESP: in-flight op dropped, all state returns to reset values immediately; no response is produced after deassertion.
  - io_alu_* registers hold their last value in IDLE (no toggling).

Optional Feature:
- Macro: ALU_SHARE_ARBITER_PERF_EN.
- Defined:
  - io_perf_busy increments on every cycle the state is not IDLE.
  - io_perf_conflict increments on every cycle with an accept while two or more io_req_valid bits are set.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package alu_share_pkg holds:
  - FN code constants: ADD=0, SL=1, SEQ=2, SNE=3, XOR=4, SR=5, OR=6, AND=7, SUB=10, SRA=11, SLT=12, SGE=13, SLTU=14, SGEU=15.
  - State encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One natural sub-module: alu_share_rr_pick, a combinational round-robin priority picker taking valid and rr and returning a one-hot grant plus its index.

Test Plan:
- Req0 ADD in1=5 in2=7, resp_ready=1 -> io_resp_valid 2 cycles after accept, data=12, id=0, cmp=0.
- Req1 SUB in1=3 in2=5 -> data=0xFFFFFFFE, id=1; then SLT in1=0xFFFFFFFF in2=1 -> data=1, cmp=1.
- Both requesters valid continuously, 6 ops, resp_ready=1 -> ids 0,1,0,1,0,1, with accepts spaced 2 cycles apart.
- resp_ready held 0 for 5 cycles while req0 pending -> resp fields stable, io_req_ready=0 throughout; on release, next op accepted in the same cycle.
- Reset pulsed low during EXEC of SRA in1=0x80000000 in2=4 -> no response; all outputs 0; the next op after reset completes normally.
- With ALU_SHARE_ARBITER_PERF_EN, 4 ops with 2 contended grants -> io_perf_conflict=2, io_perf_busy=8.
